// File: rtl/pipe_hazard_ctrl.sv
// Front-end sequencing controller: load-use stalls, taken-branch flush bubbles and
// MUL/DIV front-end hold, plus a saturating count of PC-stall cycles.
module pipe_hazard_ctrl #(
  parameter int MULDIV_LAT   = 4,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             ID_MulDiv,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_Rd,
  input  logic             BranchTaken,
  output logic             PCWrite,
  output logic             IF_ID_en,
  output logic             IF_Flush,
  output logic             ID_EX_Bubble,
  output logic             Busy,
  output logic [CNT_W-1:0] StallCycles
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_MULTI = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [7:0] MULDIV_RELOAD = 8'(MULDIV_LAT - 1);
  localparam logic [7:0] FLUSH_RELOAD  = 8'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic lu_s;
  logic pc_write_s, if_id_en_s, if_flush_s, bubble_s, busy_s;

  // Load-use hazard: EX load writes a register the ID instruction reads.
  always_comb begin
    lu_s = EX_MemRead && (EX_Rd != 5'd0) &&
           ((EX_Rd == ID_Rs) || (ID_UsesRt && (EX_Rd == ID_Rt)));
  end

  // Next-state, counter reload and front-end control outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_write_s = 1'b1;
    if_id_en_s = 1'b1;
    if_flush_s = 1'b0;
    bubble_s   = 1'b0;
    busy_s     = 1'b0;
    if (Rst) begin
      pc_write_s = 1'b0;
      if_id_en_s = 1'b0;
      if_flush_s = 1'b1;
      bubble_s   = 1'b1;
      state_d    = ST_RUN;
      cnt_d      = 8'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (BranchTaken) begin
            if_flush_s = 1'b1;
            bubble_s   = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = ST_FLUSH;
              cnt_d   = FLUSH_RELOAD;
            end else begin
              state_d = ST_RUN;
              cnt_d   = 8'd0;
            end
          end else if (lu_s) begin
            pc_write_s = 1'b0;
            if_id_en_s = 1'b0;
            bubble_s   = 1'b1;
          end else if (ID_MulDiv && (MULDIV_LAT > 1)) begin
            state_d = ST_MULTI;
            cnt_d   = MULDIV_RELOAD;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_MULTI: begin
          pc_write_s = 1'b0;
          if_id_en_s = 1'b0;
          bubble_s   = 1'b1;
          busy_s     = 1'b1;
          // <= 1 also recovers from a corrupted zero count instead of wrapping.
          if (cnt_q <= 8'd1) begin
            state_d = ST_RUN;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        ST_FLUSH: begin
          if_flush_s = 1'b1;
          bubble_s   = 1'b1;
          busy_s     = 1'b1;
          if (BranchTaken) begin
            cnt_d = FLUSH_RELOAD;
          end else if (cnt_q <= 8'd1) begin
            state_d = ST_RUN;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: begin
          pc_write_s = 1'b0;
          if_id_en_s = 1'b0;
          if_flush_s = 1'b1;
          bubble_s   = 1'b1;
          state_d    = ST_RUN;
          cnt_d      = 8'd0;
        end
      endcase
    end
  end

  // Saturating stall-cycle counter; reset cycles are not counted.
  always_comb begin
    if (Rst) begin
      stall_d = {CNT_W{1'b0}};
    end else if (!pc_write_s && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + CNT_W'(1);
    end else begin
      stall_d = stall_q;
    end
  end

  // State registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 8'd0;
      stall_q <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign PCWrite      = pc_write_s;
  assign IF_ID_en     = if_id_en_s;
  assign IF_Flush     = if_flush_s;
  assign ID_EX_Bubble = bubble_s;
  assign Busy         = busy_s;
  assign StallCycles  = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: u0 uses defaults (LAT=4, FLUSH=1, CNT_W=32); u1 uses LAT=1, FLUSH=3,
// CNT_W=4. Outputs packed as {PCWrite, IF_ID_en, IF_Flush, ID_EX_Bubble, Busy}.
module tb_pipe_hazard_ctrl;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [4:0] ID_Rs, ID_Rt, EX_Rd;
  logic       ID_UsesRt, ID_MulDiv, EX_MemRead, BranchTaken;

  logic        pc0, en0, fl0, bb0, by0;
  logic        pc1, en1, fl1, bb1, by1;
  logic [31:0] stall0;
  logic [3:0]  stall1;
  logic [4:0]  o0, o1;

  int n_cmp = 0;
  int n_err = 0;

  assign o0 = {pc0, en0, fl0, bb0, by0};
  assign o1 = {pc1, en1, fl1, bb1, by1};

  always #5 Clk = ~Clk;

  pipe_hazard_ctrl u0 (
    .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .ID_MulDiv(ID_MulDiv), .EX_MemRead(EX_MemRead), .EX_Rd(EX_Rd),
    .BranchTaken(BranchTaken), .PCWrite(pc0), .IF_ID_en(en0), .IF_Flush(fl0),
    .ID_EX_Bubble(bb0), .Busy(by0), .StallCycles(stall0)
  );

  pipe_hazard_ctrl #(.MULDIV_LAT(1), .FLUSH_CYCLES(3), .CNT_W(4)) u1 (
    .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .ID_MulDiv(ID_MulDiv), .EX_MemRead(EX_MemRead), .EX_Rd(EX_Rd),
    .BranchTaken(BranchTaken), .PCWrite(pc1), .IF_ID_en(en1), .IF_Flush(fl1),
    .ID_EX_Bubble(bb1), .Busy(by1), .StallCycles(stall1)
  );

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr();
    ID_Rs = 5'd0; ID_Rt = 5'd0; EX_Rd = 5'd0;
    ID_UsesRt = 1'b0; ID_MulDiv = 1'b0; EX_MemRead = 1'b0; BranchTaken = 1'b0;
  endtask

  task automatic do_reset();
    Rst = 1'b1; clr();
    cyc();
    Rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b1; clr();
    #1;
    n_cmp++; if (o0 !== 5'b00110) begin n_err++; $display("FAIL reset_outs: got %b want %b", o0, 5'b00110); end
    cyc();
    n_cmp++; if (o1 !== 5'b00110) begin n_err++; $display("FAIL reset_outs_u1: got %b want %b", o1, 5'b00110); end
    n_cmp++; if (stall0 !== 32'd0) begin n_err++; $display("FAIL reset_stall: got %0d want %0d", stall0, 0); end
    Rst = 1'b0;
    #1;
    n_cmp++; if (o0 !== 5'b11000) begin n_err++; $display("FAIL run_default: got %b want %b", o0, 5'b11000); end
  endtask

  task automatic test_load_use();
    EX_MemRead = 1'b1; EX_Rd = 5'd5; ID_Rs = 5'd5;
    #1;
    n_cmp++; if (o0 !== 5'b00010) begin n_err++; $display("FAIL lu_rs: got %b want %b", o0, 5'b00010); end
    cyc(); clr(); #1;
    n_cmp++; if (o0 !== 5'b11000) begin n_err++; $display("FAIL lu_clear: got %b want %b", o0, 5'b11000); end
    n_cmp++; if (stall0 !== 32'd1) begin n_err++; $display("FAIL lu_stall1: got %0d want %0d", stall0, 1); end
    EX_MemRead = 1'b1; EX_Rd = 5'd7; ID_Rs = 5'd3; ID_Rt = 5'd7; ID_UsesRt = 1'b1;
    #1;
    n_cmp++; if (o0 !== 5'b00010) begin n_err++; $display("FAIL lu_rt: got %b want %b", o0, 5'b00010); end
    cyc(); clr(); #1;
    n_cmp++; if (stall0 !== 32'd2) begin n_err++; $display("FAIL lu_stall2: got %0d want %0d", stall0, 2); end
  endtask

  task automatic test_no_hazard();
    EX_MemRead = 1'b1; EX_Rd = 5'd0; ID_Rs = 5'd0;
    #1;
    n_cmp++; if (o0 !== 5'b11000) begin n_err++; $display("FAIL nh_r0: got %b want %b", o0, 5'b11000); end
    EX_Rd = 5'd5; ID_Rs = 5'd3; ID_Rt = 5'd5; ID_UsesRt = 1'b0;
    #1;
    n_cmp++; if (o0 !== 5'b11000) begin n_err++; $display("FAIL nh_rt_unused: got %b want %b", o0, 5'b11000); end
    EX_MemRead = 1'b0; ID_Rs = 5'd5;
    #1;
    n_cmp++; if (o0 !== 5'b11000) begin n_err++; $display("FAIL nh_not_load: got %b want %b", o0, 5'b11000); end
    cyc(); clr(); #1;
    n_cmp++; if (stall0 !== 32'd2) begin n_err++; $display("FAIL nh_stall: got %0d want %0d", stall0, 2); end
  endtask

  task automatic test_muldiv();
    ID_MulDiv = 1'b1;
    #1;
    n_cmp++; if (o0 !== 5'b11000) begin n_err++; $display("FAIL md_issue: got %b want %b", o0, 5'b11000); end
    cyc(); clr(); #1;
    n_cmp++; if (o0 !== 5'b00011) begin n_err++; $display("FAIL md_c1: got %b want %b", o0, 5'b00011); end
    n_cmp++; if (o1 !== 5'b11000) begin n_err++; $display("FAIL md_lat1_no_multi: got %b want %b", o1, 5'b11000); end
    cyc();
    BranchTaken = 1'b1; EX_MemRead = 1'b1; EX_Rd = 5'd4; ID_Rs = 5'd4;
    #1;
    n_cmp++; if (o0 !== 5'b00011) begin n_err++; $display("FAIL md_c2_ignore: got %b want %b", o0, 5'b00011); end
    cyc(); clr(); #1;
    n_cmp++; if (o0 !== 5'b00011) begin n_err++; $display("FAIL md_c3: got %b want %b", o0, 5'b00011); end
    cyc();
    n_cmp++; if (o0 !== 5'b11000) begin n_err++; $display("FAIL md_done: got %b want %b", o0, 5'b11000); end
    n_cmp++; if (stall0 !== 32'd5) begin n_err++; $display("FAIL md_stall: got %0d want %0d", stall0, 5); end
  endtask

  task automatic test_branch_priority();
    BranchTaken = 1'b1; ID_MulDiv = 1'b1; EX_MemRead = 1'b1; EX_Rd = 5'd9; ID_Rs = 5'd9;
    #1;
    n_cmp++; if (o0 !== 5'b11110) begin n_err++; $display("FAIL br_prio: got %b want %b", o0, 5'b11110); end
    cyc(); clr(); #1;
    n_cmp++; if (o0 !== 5'b11000) begin n_err++; $display("FAIL br_after: got %b want %b", o0, 5'b11000); end
    n_cmp++; if (stall0 !== 32'd5) begin n_err++; $display("FAIL br_stall: got %0d want %0d", stall0, 5); end
  endtask

  task automatic test_flush();
    do_reset();
    BranchTaken = 1'b1;
    #1;
    n_cmp++; if (o1 !== 5'b11110) begin n_err++; $display("FAIL fl_c1: got %b want %b", o1, 5'b11110); end
    cyc(); clr(); #1;
    n_cmp++; if (o1 !== 5'b11111) begin n_err++; $display("FAIL fl_c2: got %b want %b", o1, 5'b11111); end
    cyc();
    n_cmp++; if (o1 !== 5'b11111) begin n_err++; $display("FAIL fl_c3: got %b want %b", o1, 5'b11111); end
    cyc();
    n_cmp++; if (o1 !== 5'b11000) begin n_err++; $display("FAIL fl_end: got %b want %b", o1, 5'b11000); end
    BranchTaken = 1'b1;
    cyc();
    n_cmp++; if (o1 !== 5'b11111) begin n_err++; $display("FAIL flr_c2: got %b want %b", o1, 5'b11111); end
    cyc(); clr(); #1;
    n_cmp++; if (o1 !== 5'b11111) begin n_err++; $display("FAIL flr_c3: got %b want %b", o1, 5'b11111); end
    cyc();
    n_cmp++; if (o1 !== 5'b11111) begin n_err++; $display("FAIL flr_c4: got %b want %b", o1, 5'b11111); end
    cyc();
    n_cmp++; if (o1 !== 5'b11000) begin n_err++; $display("FAIL flr_end: got %b want %b", o1, 5'b11000); end
    n_cmp++; if (stall1 !== 4'd0) begin n_err++; $display("FAIL fl_stall: got %0d want %0d", stall1, 0); end
  endtask

  task automatic test_reset_mid_multi();
    do_reset();
    ID_MulDiv = 1'b1;
    cyc(); clr(); #1;
    n_cmp++; if (o0 !== 5'b00011) begin n_err++; $display("FAIL rm_c1: got %b want %b", o0, 5'b00011); end
    cyc();
    Rst = 1'b1;
    #1;
    n_cmp++; if (o0 !== 5'b00110) begin n_err++; $display("FAIL rm_reset_outs: got %b want %b", o0, 5'b00110); end
    cyc();
    Rst = 1'b0;
    #1;
    n_cmp++; if (o0 !== 5'b11000) begin n_err++; $display("FAIL rm_run: got %b want %b", o0, 5'b11000); end
    n_cmp++; if (stall0 !== 32'd0) begin n_err++; $display("FAIL rm_stall: got %0d want %0d", stall0, 0); end
  endtask

  task automatic test_saturation();
    EX_MemRead = 1'b1; EX_Rd = 5'd6; ID_Rs = 5'd6;
    for (int i = 0; i < 14; i++) cyc();
    n_cmp++; if (stall1 !== 4'd14) begin n_err++; $display("FAIL sat_14: got %0d want %0d", stall1, 14); end
    cyc();
    n_cmp++; if (stall1 !== 4'd15) begin n_err++; $display("FAIL sat_15: got %0d want %0d", stall1, 15); end
    for (int i = 0; i < 3; i++) cyc();
    n_cmp++; if (stall1 !== 4'd15) begin n_err++; $display("FAIL sat_hold: got %0d want %0d", stall1, 15); end
    n_cmp++; if (stall0 !== 32'd18) begin n_err++; $display("FAIL sat_wide: got %0d want %0d", stall0, 18); end
    clr();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_muldiv();
    test_branch_priority();
    test_flush();
    test_reset_mid_multi();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
